// File: rtl/adder4_nibble_sched_if.sv
// Bundles the requester, result and adder-core signals of adder4_nibble_sched.
// The slave modport is the scheduler's view; master is the environment's view.
interface adder4_nibble_sched_if #(
  parameter int W = 16
);
  // Handshakes: a transfer happens on the rising edge where valid & ready are both high.
  // Valid never waits for ready, and payload stays stable while valid waits for ready.
  logic [1:0]     in_valid;
  logic [1:0]     in_ready;
  logic [2*W-1:0] in_a;
  logic [2*W-1:0] in_b;
  logic [1:0]     in_cin;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_sum;
  logic           out_cout;
  logic           out_id;
  logic           busy;
  logic [3:0]     add_a;
  logic [3:0]     add_b;
  logic           add_cin;
  logic [3:0]     add_sum;
  logic           add_cout;
  logic [1:0]     dbg_state;
  logic           dbg_rr_ptr;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, out_id, busy,
           add_a, add_b, add_cin, dbg_state, dbg_rr_ptr
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, out_id, busy,
           add_a, add_b, add_cin, dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/adder4_nibble_sched.sv
// Two-requester scheduler that performs W-bit additions nibble-serially through one
// external 4-bit adder core, chaining the carry through a register, LSB nibble first.
module adder4_nibble_sched #(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder4_nibble_sched_if.slave  bus
);
  localparam int NIB = W / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [W-1:0]  a_q,      a_d;
  logic [W-1:0]  b_q,      b_d;
  logic [W-1:0]  sum_q,    sum_d;
  logic          cin_q,    cin_d;
  logic          id_q,     id_d;
  logic          carry_q,  carry_d;
  logic [NW-1:0] nib_q,    nib_d;

  logic          grant_vld;
  logic          grant_id;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic          last_nib;
  logic          in_run;

  // Round-robin: the side at rr_ptr has priority, the other side is served only if it is idle.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = rr_ptr_q;
    if (state_q == S_IDLE) begin
      if (bus.in_valid[rr_ptr_q]) begin
        grant_vld = 1'b1;
        grant_id  = rr_ptr_q;
      end else if (bus.in_valid[~rr_ptr_q]) begin
        grant_vld = 1'b1;
        grant_id  = ~rr_ptr_q;
      end
    end
  end

  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (nib_q == NW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  assign last_nib = (nib_q == NW'(NIB - 1));
  assign in_run   = (state_q == S_RUN);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cin_d    = cin_q;
    id_d     = id_q;
    carry_d  = carry_q;
    nib_d    = nib_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          a_d      = grant_id ? bus.in_a[2*W-1:W] : bus.in_a[W-1:0];
          b_d      = grant_id ? bus.in_b[2*W-1:W] : bus.in_b[W-1:0];
          cin_d    = bus.in_cin[grant_id];
          id_d     = grant_id;
          nib_d    = '0;
          rr_ptr_d = ~grant_id;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (nib_q == NW'(i)) sum_d[4*i +: 4] = bus.add_sum;
        end
        carry_d = bus.add_cout;
        if (last_nib) begin
          nib_d   = '0;
          state_d = S_DONE;
        end else begin
          nib_d = nib_q + NW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cin_q    <= 1'b0;
      id_q     <= 1'b0;
      carry_q  <= 1'b0;
      nib_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cin_q    <= cin_d;
      id_q     <= id_d;
      carry_q  <= carry_d;
      nib_q    <= nib_d;
    end
  end

  assign bus.in_ready   = grant_vld ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_sum    = sum_q;
  assign bus.out_cout   = carry_q;
  assign bus.out_id     = id_q;
  assign bus.busy       = (state_q == S_RUN) || (state_q == S_DONE);
  // The core is only driven during RUN so its inputs stay quiet otherwise.
  assign bus.add_a      = in_run ? nib_a : 4'h0;
  assign bus.add_b      = in_run ? nib_b : 4'h0;
  assign bus.add_cin    = in_run ? ((nib_q == '0) ? cin_q : carry_q) : 1'b0;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;
endmodule
